// File: rtl/calc_sequenciador_entrada.sv
// Input sequencer for the 8-bit calculator: captures A, op and B on button presses, holds result.
// Optional macro CALC_DEBOUNCE_EN adds a per-button debounce counter ahead of edge detection.
module calc_sequenciador_entrada #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] chaves,
    input  logic [2:0] op_chaves,
    input  logic       btn_enter,
    input  logic       btn_limpar,
    input  logic [7:0] saida_calc,
    output logic [7:0] entrada_A,
    output logic [7:0] entrada_B,
    output logic [2:0] codigo,
    output logic [7:0] resultado,
    output logic [2:0] estado,
    output logic       pronto,
    output logic       erro_op
);

    typedef enum logic [2:0] {
        CapA   = 3'b000,
        CapOp  = 3'b001,
        CapB   = 3'b010,
        Exec   = 3'b011,
        Result = 3'b100
    } estado_t;

    estado_t                estado_q;
    logic [2:0]             op_q;
    logic [SYNC_STAGES-1:0] enter_sync;
    logic [SYNC_STAGES-1:0] limpar_sync;
    logic                   enter_lvl;
    logic                   limpar_lvl;
    logic                   enter_prev;
    logic                   limpar_prev;
    logic                   enter_p;
    logic                   limpar_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_sync  <= '0;
            limpar_sync <= '0;
        end else begin
            enter_sync  <= {enter_sync[SYNC_STAGES-2:0], btn_enter};
            limpar_sync <= {limpar_sync[SYNC_STAGES-2:0], btn_limpar};
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] enter_cnt;
    logic [CntW-1:0] limpar_cnt;
    logic            enter_deb;
    logic            limpar_deb;

    // Any cycle back at the accepted level restarts the count, so short glitches never pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_cnt  <= '0;
            limpar_cnt <= '0;
            enter_deb  <= 1'b0;
            limpar_deb <= 1'b0;
        end else begin
            if (enter_sync[SYNC_STAGES-1] == enter_deb) begin
                enter_cnt <= '0;
            end else if (enter_cnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
                enter_deb <= enter_sync[SYNC_STAGES-1];
                enter_cnt <= '0;
            end else begin
                enter_cnt <= enter_cnt + 1'b1;
            end
            if (limpar_sync[SYNC_STAGES-1] == limpar_deb) begin
                limpar_cnt <= '0;
            end else if (limpar_cnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
                limpar_deb <= limpar_sync[SYNC_STAGES-1];
                limpar_cnt <= '0;
            end else begin
                limpar_cnt <= limpar_cnt + 1'b1;
            end
        end
    end

    assign enter_lvl  = enter_deb;
    assign limpar_lvl = limpar_deb;
`else
    assign enter_lvl  = enter_sync[SYNC_STAGES-1];
    assign limpar_lvl = limpar_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_prev  <= 1'b0;
            limpar_prev <= 1'b0;
        end else begin
            enter_prev  <= enter_lvl;
            limpar_prev <= limpar_lvl;
        end
    end

    assign enter_p  = enter_lvl & ~enter_prev;
    assign limpar_p = limpar_lvl & ~limpar_prev;

    // codigo is registered alongside the state so it changes on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= CapA;
            op_q      <= 3'b000;
            entrada_A <= 8'h00;
            entrada_B <= 8'h00;
            codigo    <= 3'b000;
            resultado <= 8'h00;
            pronto    <= 1'b0;
            erro_op   <= 1'b0;
        end else begin
            erro_op <= 1'b0;
            if (limpar_p) begin
                entrada_A <= 8'h00;
                entrada_B <= 8'h00;
                resultado <= 8'h00;
                pronto    <= 1'b0;
                codigo    <= 3'b000;
                estado_q  <= CapA;
            end else begin
                case (estado_q)
                    CapA: begin
                        if (enter_p) begin
                            entrada_A <= chaves;
                            codigo    <= 3'b001;
                            estado_q  <= CapOp;
                        end
                    end
                    CapOp: begin
                        if (enter_p) begin
                            if (op_chaves == 3'b011 || op_chaves == 3'b100) begin
                                op_q     <= op_chaves;
                                estado_q <= CapB;
                            end else begin
                                erro_op <= 1'b1;
                            end
                        end
                    end
                    CapB: begin
                        if (enter_p) begin
                            entrada_B <= chaves;
                            codigo    <= op_q;
                            estado_q  <= Exec;
                        end
                    end
                    Exec: begin
                        resultado <= saida_calc;
                        pronto    <= 1'b1;
                        estado_q  <= Result;
                    end
                    Result: begin
                        if (enter_p) begin
                            pronto   <= 1'b0;
                            codigo   <= 3'b000;
                            estado_q <= CapA;
                        end
                    end
                    default: begin
                        pronto   <= 1'b0;
                        codigo   <= 3'b000;
                        estado_q <= CapA;
                    end
                endcase
            end
        end
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_calc_sequenciador_entrada.sv
// Directed-vector bench for calc_sequenciador_entrada with a small add/sub calculator model.
module tb_calc_sequenciador_entrada;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] chaves = 8'h00;
    logic [2:0] op_chaves = 3'b000;
    logic       btn_enter = 1'b0;
    logic       btn_limpar = 1'b0;
    logic [7:0] saida_calc;
    logic [7:0] entrada_A;
    logic [7:0] entrada_B;
    logic [2:0] codigo;
    logic [7:0] resultado;
    logic [2:0] estado;
    logic       pronto;
    logic       erro_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Calculator stage: 011 adds, 100 subtracts.
    assign saida_calc = (codigo == 3'b011) ? entrada_A + entrada_B :
                        (codigo == 3'b100) ? entrada_A - entrada_B : 8'h00;

    calc_sequenciador_entrada dut (
        .clk        (clk),
        .rst        (rst),
        .chaves     (chaves),
        .op_chaves  (op_chaves),
        .btn_enter  (btn_enter),
        .btn_limpar (btn_limpar),
        .saida_calc (saida_calc),
        .entrada_A  (entrada_A),
        .entrada_B  (entrada_B),
        .codigo     (codigo),
        .resultado  (resultado),
        .estado     (estado),
        .pronto     (pronto),
        .erro_op    (erro_op)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_enter = 1'b0;
        btn_limpar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_enter(input int hold);
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(negedge clk);
        total++; if (estado !== 3'b000) begin bad++; $display("FAIL reset_estado got=%h want=%h", estado, 3'b000); end
        total++; if (codigo !== 3'b000) begin bad++; $display("FAIL reset_codigo got=%h want=%h", codigo, 3'b000); end
        total++; if (entrada_A !== 8'h00) begin bad++; $display("FAIL reset_A got=%h want=%h", entrada_A, 8'h00); end
        total++; if (entrada_B !== 8'h00) begin bad++; $display("FAIL reset_B got=%h want=%h", entrada_B, 8'h00); end
        total++; if (resultado !== 8'h00) begin bad++; $display("FAIL reset_res got=%h want=%h", resultado, 8'h00); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto got=%b want=0", pronto); end
        total++; if (erro_op !== 1'b0) begin bad++; $display("FAIL reset_erro got=%b want=0", erro_op); end
    endtask

    task automatic test_add();
        int exec_cycles;
        logic [2:0] exec_cod;
        do_reset();
        chaves = 8'h12;
        press_enter(1);
        total++; if (estado !== 3'b001) begin bad++; $display("FAIL add_st_op got=%h want=%h", estado, 3'b001); end
        total++; if (codigo !== 3'b001) begin bad++; $display("FAIL add_cod_op got=%h want=%h", codigo, 3'b001); end
        total++; if (entrada_A !== 8'h12) begin bad++; $display("FAIL add_A got=%h want=%h", entrada_A, 8'h12); end
        op_chaves = 3'b011;
        press_enter(1);
        total++; if (estado !== 3'b010) begin bad++; $display("FAIL add_st_b got=%h want=%h", estado, 3'b010); end
        total++; if (codigo !== 3'b001) begin bad++; $display("FAIL add_cod_b got=%h want=%h", codigo, 3'b001); end
        chaves = 8'h05;
        exec_cycles = 0;
        exec_cod = 3'b000;
        @(negedge clk);
        btn_enter = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_enter = 1'b0;
            if (estado == 3'b011) begin
                exec_cycles++;
                exec_cod = codigo;
            end
        end
        total++; if (exec_cycles !== 1) begin bad++; $display("FAIL add_exec_len got=%0d want=1", exec_cycles); end
        total++; if (exec_cod !== 3'b011) begin bad++; $display("FAIL add_exec_cod got=%h want=%h", exec_cod, 3'b011); end
        total++; if (resultado !== 8'h17) begin bad++; $display("FAIL add_res got=%h want=%h", resultado, 8'h17); end
        total++; if (pronto !== 1'b1) begin bad++; $display("FAIL add_pronto got=%b want=1", pronto); end
        total++; if (estado !== 3'b100) begin bad++; $display("FAIL add_st_res got=%h want=%h", estado, 3'b100); end
        total++; if (entrada_B !== 8'h05) begin bad++; $display("FAIL add_B got=%h want=%h", entrada_B, 8'h05); end
        press_enter(1);
        total++; if (estado !== 3'b000) begin bad++; $display("FAIL add_back_st got=%h want=%h", estado, 3'b000); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL add_back_pronto got=%b want=0", pronto); end
        total++; if (entrada_A !== 8'h12) begin bad++; $display("FAIL add_keep_A got=%h want=%h", entrada_A, 8'h12); end
        total++; if (resultado !== 8'h17) begin bad++; $display("FAIL add_keep_res got=%h want=%h", resultado, 8'h17); end
    endtask

    task automatic test_invalid_op();
        int err_cycles;
        do_reset();
        chaves = 8'h30;
        press_enter(1);
        op_chaves = 3'b110;
        err_cycles = 0;
        @(negedge clk);
        btn_enter = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_enter = 1'b0;
            if (erro_op) err_cycles++;
        end
        total++; if (err_cycles !== 1) begin bad++; $display("FAIL inv_erro_len got=%0d want=1", err_cycles); end
        total++; if (estado !== 3'b001) begin bad++; $display("FAIL inv_st got=%h want=%h", estado, 3'b001); end
        op_chaves = 3'b100;
        press_enter(1);
        total++; if (estado !== 3'b010) begin bad++; $display("FAIL inv_st_b got=%h want=%h", estado, 3'b010); end
        chaves = 8'h10;
        press_enter(1);
        total++; if (codigo !== 3'b100) begin bad++; $display("FAIL sub_cod got=%h want=%h", codigo, 3'b100); end
        total++; if (resultado !== 8'h20) begin bad++; $display("FAIL sub_res got=%h want=%h", resultado, 8'h20); end
        // Clear from RESULT drops the held result.
        @(negedge clk);
        btn_limpar = 1'b1;
        @(negedge clk);
        btn_limpar = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (resultado !== 8'h00) begin bad++; $display("FAIL clr_res got=%h want=%h", resultado, 8'h00); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL clr_pronto got=%b want=0", pronto); end
        total++; if (codigo !== 3'b000) begin bad++; $display("FAIL clr_cod got=%h want=%h", codigo, 3'b000); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        chaves = 8'h44;
        press_enter(1);
        op_chaves = 3'b011;
        press_enter(1);
        chaves = 8'h09;
        @(negedge clk);
        btn_enter = 1'b1;
        btn_limpar = 1'b1;
        @(negedge clk);
        btn_enter = 1'b0;
        btn_limpar = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (estado !== 3'b000) begin bad++; $display("FAIL prio_st got=%h want=%h", estado, 3'b000); end
        total++; if (entrada_A !== 8'h00) begin bad++; $display("FAIL prio_A got=%h want=%h", entrada_A, 8'h00); end
        total++; if (entrada_B !== 8'h00) begin bad++; $display("FAIL prio_B got=%h want=%h", entrada_B, 8'h00); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL prio_pronto got=%b want=0", pronto); end
    endtask

    task automatic test_held_button();
        int transitions;
        logic [2:0] prev;
        do_reset();
        chaves = 8'h5a;
        transitions = 0;
        prev = estado;
        @(negedge clk);
        btn_enter = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (estado !== prev) transitions++;
            prev = estado;
        end
        btn_enter = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (transitions !== 1) begin bad++; $display("FAIL held_trans got=%0d want=1", transitions); end
        total++; if (estado !== 3'b001) begin bad++; $display("FAIL held_st got=%h want=%h", estado, 3'b001); end
        total++; if (entrada_A !== 8'h5a) begin bad++; $display("FAIL held_A got=%h want=%h", entrada_A, 8'h5a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        chaves = 8'h77;
        press_enter(1);
        op_chaves = 3'b011;
        press_enter(1);
        #2;
        rst = 1'b1;
        #1;
        total++; if (estado !== 3'b000) begin bad++; $display("FAIL mid_st got=%h want=%h", estado, 3'b000); end
        total++; if (entrada_A !== 8'h00) begin bad++; $display("FAIL mid_A got=%h want=%h", entrada_A, 8'h00); end
        total++; if (codigo !== 3'b000) begin bad++; $display("FAIL mid_cod got=%h want=%h", codigo, 3'b000); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_invalid_op();
        test_clear_priority();
        test_held_button();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequenciador_entrada.md
Name: calc_sequenciador_entrada

Overview:
- Upstream control stage for the 8-bit calculator datapath.
- Collects operand A, the operation code and operand B from switches, one per press of an "enter" button.
- Drives the calculator's A, B and code inputs, then latches the calculator's combinational result into a held register.
- Contains button synchroniser/edge detector, capture FSM and result register.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the button synchronisers (minimum 2).
- DEBOUNCE_CYCLES, 16, stable-level cycles required before a button change is accepted (used only with CALC_DEBOUNCE_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- chaves  input  8  switch value captured as operand A or B.
- op_chaves  input  3  switch value captured as operation code.
- btn_enter  input  1  asynchronous button, active-high.
- btn_limpar  input  1  asynchronous clear button, active-high.
- saida_calc  input  8  result returned by the calculator stage.
- entrada_A  output  8  registered operand A to the calculator.
- entrada_B  output  8  registered operand B to the calculator.
- codigo  output  3  registered operation code to the calculator.
- resultado  output  8  latched result.
- estado  output  3  current FSM state encoding, for debug LEDs.
- pronto  output  1  high while resultado is valid.
- erro_op  output  1  one-cycle pulse on rejected op code.

Behaviour:
- Reset, asynchronous and active-high:
  - entrada_A, entrada_B and resultado = 0.
  - codigo = 000.
  - estado = CAP_A.
  - pronto = 0, erro_op = 0.
  - Synchroniser and edge-detect flops = 0.
- Buttons: each passes through a SYNC_STAGES flop chain. A rising-edge detector produces a one-cycle pulse (enter_p, limpar_p).
- Latency: a btn_enter rise at edge N yields enter_p during cycle N+SYNC_STAGES. The state update follows at the next edge.
- FSM states (estado encoding):
  - CAP_A (000): codigo = 000. On enter_p: entrada_A <= chaves, go to CAP_OP.
  - CAP_OP (001): codigo = 001, showing A. On enter_p:
    - If op_chaves is 011 or 100: store the op internally, go to CAP_B.
    - Otherwise: stay in CAP_OP, pulse erro_op for 1 cycle, op register unchanged.
  - CAP_B (010): codigo = 001. On enter_p: entrada_B <= chaves, go to EXEC.
  - EXEC (011): codigo = stored op for exactly 1 cycle. Calculator output settles combinationally; at the end of the cycle resultado <= saida_calc, pronto <= 1, go to RESULT.
  - RESULT (100): codigo = stored op, pronto = 1. On enter_p: pronto <= 0, go to CAP_A. Operands are kept until overwritten.
- limpar_p in any state:
  - entrada_A, entrada_B, resultado <= 0; pronto <= 0; go to CAP_A.
  - Takes priority over a simultaneous enter_p, which is dropped.
- enter_p in EXEC is ignored. There is no queueing; only one pulse per button press.
- A held button generates only one pulse. A new pulse needs the button to return low (through the synchroniser) first.
- Illegal state encodings (101–111) recover to CAP_A on the next edge.
- Reset asserted mid-sequence (e.g. in CAP_B) immediately returns all outputs to their reset values. Partially captured operands are lost.
- No arithmetic is done here; widths are passed through unchanged.

Optional Feature:
- Macro: CALC_DEBOUNCE_EN.
- Defined: each synchronised button feeds a counter (width clog2(DEBOUNCE_CYCLES+1)). The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level. Edge detection uses the debounced level, adding DEBOUNCE_CYCLES cycles of latency. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: the synchronised level drives edge detection directly, with no counter logic.

Test Plan:
- Reset then idle -> estado=000, codigo=000, all 8-bit outputs 0, pronto=0.
- Normal add: chaves=0x12 and press enter; op_chaves=011 and press; chaves=0x05 and press; model saida_calc=0x17 -> EXEC lasts 1 cycle with codigo=011, then resultado=0x17, pronto=1, estado=100.
- Invalid op: in CAP_OP with op_chaves=110, press enter -> erro_op high for exactly 1 cycle, estado stays 001. Then op_chaves=100 and press -> estado=010.
- Clear priority: in CAP_B, press enter and limpar in the same cycle -> estado=000, entrada_A=0, entrada_B unchanged at 0, pronto=0.
- Held button: hold btn_enter high for 50 cycles in CAP_A -> exactly one transition, to CAP_OP.
- With CALC_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle enter glitch produces no transition; a 20-cycle press produces one transition, 16+SYNC_STAGES cycles after the rise.
